dmem_mmio_responder: RTL and testbench

- Responder on the processor's data-memory port, between the processor's dmem initiator signals and the dmem syncram.
- Accesses below MMIO_BASE pass through to dmem. Accesses at or above MMIO_BASE hit local registers:
  - free-running cycle counter
  - probe register
  - byte TX FIFO with a valid/ready drain port toward an output sink (UART/LED driver)
- Read data has the same timing as the inverted-clock syncram, so the processor needs no changes.

---
 rtl/dmem_mmio_responder_pkg.sv | 18 +
 rtl/dmem_mmio_responder_fifo.sv | 79 +++++++
 rtl/dmem_mmio_responder.sv | 109 ++++++++++
 tb/tb_dmem_mmio_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the dmem/MMIO responder: MMIO window base, register
// offsets and STATUS bit positions.
package dmem_mmio_responder_pkg;

  localparam logic [11:0] MMIO_BASE = 12'hF00;

  localparam logic [11:0] OFF_CYCLE  = 12'd0;
  localparam logic [11:0] OFF_PROBE  = 12'd1;
  localparam logic [11:0] OFF_TXDATA = 12'd2;
  localparam logic [11:0] OFF_STATUS = 12'd3;

  localparam int ST_EMPTY    = 0;
  localparam int ST_COUNT_LO = 1;
  localparam int ST_COUNT_HI = 3;
  localparam int ST_FULL     = 5;
  localparam int ST_OVF      = 8;

endpackage

// File: rtl/dmem_mmio_responder_fifo.sv
// Byte TX FIFO behind the TXDATA register: circular buffer with a sticky
// overflow flag and a valid/ready drain port. State moves on the falling edge.
module mmio_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_ovf_clr,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count,
  output logic             o_ovf
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic [CW-1:0]    w_count_nxt;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // accepted only when the sink drains simultaneously; no bypass when empty.
  assign w_pop     = i_pop & ~w_empty;
  assign w_push_ok = i_push & (~w_full | w_pop);
  assign w_drop    = i_push & w_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o_valid = ~w_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: passes low addresses to the dmem syncram and
// serves CYCLE/PROBE/TXDATA/STATUS above MMIO_BASE with syncram-like timing.
module dmem_mmio_responder #(
  parameter logic [11:0] MMIO_BASE  = dmem_mmio_responder_pkg::MMIO_BASE,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic [31:0] probe,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  import dmem_mmio_responder_pkg::*;

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CBITS = (CW < 3) ? CW : 3;

  logic [CNT_W-1:0] r_cycle;
  logic [31:0]      r_probe;
  logic             r_is_mmio_q;
  logic [31:0]      r_mmio_rdata_q;

  logic             w_is_mmio;
  logic [11:0]      w_offset;
  logic             w_wr_mmio;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_clr;
  logic [31:0]      w_status;
  logic [31:0]      w_rdata;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic             w_fifo_ovf;
  logic [CW-1:0]    w_fifo_count;

  assign w_is_mmio = (address_dmem >= MMIO_BASE);
  assign w_offset  = address_dmem - MMIO_BASE;
  assign mem_wren  = wren & ~w_is_mmio;
  assign w_wr_mmio = wren & w_is_mmio;
  assign w_push    = w_wr_mmio & (w_offset == OFF_TXDATA);
  assign w_pop     = tx_valid & tx_ready;
  assign w_ovf_clr = w_wr_mmio & (w_offset == OFF_STATUS) & data[ST_OVF];

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .i_push    (w_push),
    .i_wdata   (data[7:0]),
    .i_pop     (w_pop),
    .i_ovf_clr (w_ovf_clr),
    .o_valid   (tx_valid),
    .o_rdata   (tx_data),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full),
    .o_count   (w_fifo_count),
    .o_ovf     (w_fifo_ovf)
  );

  always_comb begin
    w_status = '0;
    w_status[ST_EMPTY] = w_fifo_empty;
    w_status[ST_COUNT_LO +: CBITS] = w_fifo_count[CBITS-1:0];
    w_status[ST_FULL] = w_fifo_full;
    w_status[ST_OVF] = w_fifo_ovf;
  end

  always_comb begin
    w_rdata = '0;
    case (w_offset)
      OFF_CYCLE:  w_rdata = 32'(r_cycle);
      OFF_PROBE:  w_rdata = r_probe;
      OFF_STATUS: w_rdata = w_status;
      default:    w_rdata = '0;
    endcase
  end

  // Read data is captured on the same falling edge as the syncram, so the
  // processor sees MMIO and dmem reads with identical latency.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle        <= '0;
      r_probe        <= '0;
      r_is_mmio_q    <= 1'b0;
      r_mmio_rdata_q <= '0;
    end else begin
      if (w_wr_mmio && (w_offset == OFF_CYCLE)) r_cycle <= '0;
      else                                      r_cycle <= r_cycle + CNT_W'(1);
      if (w_wr_mmio && (w_offset == OFF_PROBE)) r_probe <= data;
      r_is_mmio_q    <= w_is_mmio;
      r_mmio_rdata_q <= w_rdata;
    end
  end

  assign q_dmem = r_is_mmio_q ? r_mmio_rdata_q : mem_q;
  assign probe  = r_probe;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: bus driver tasks, a dmem syncram
// model, a TX byte scoreboard and a small-counter instance for wrap-around.
module tb_dmem_mmio_responder;

  localparam logic [11:0] A_CYCLE  = 12'hF00;
  localparam logic [11:0] A_PROBE  = 12'hF01;
  localparam logic [11:0] A_TXDATA = 12'hF02;
  localparam logic [11:0] A_STATUS = 12'hF03;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic [31:0] probe;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  logic [31:0] q_small;
  logic        mem_wren_small;
  logic [31:0] probe_small;
  logic        tx_valid_small;
  logic [7:0]  tx_data_small;

  logic [31:0] dmem [4096];
  logic [7:0]  exp_q[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] r_q;
  logic [31:0] r_q_small;
  logic        r_wren_seen;
  logic [31:0] v0;

  dmem_mmio_responder u_dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q),
    .probe        (probe),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready)
  );

  dmem_mmio_responder #(.CNT_W(4)) u_dut_small (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_small),
    .mem_wren     (mem_wren_small),
    .mem_q        (mem_q),
    .probe        (probe_small),
    .tx_valid     (tx_valid_small),
    .tx_data      (tx_data_small),
    .tx_ready     (1'b0)
  );

  // clock / reset
  always #5 clock = ~clock;

  // dmem syncram model, clocked on the falling edge like the real part
  always @(negedge clock) begin
    if (mem_wren) dmem[address_dmem] <= data;
    mem_q <= dmem[address_dmem];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // TX scoreboard: sample 1 ns before the falling edge that performs the pop
  always @(posedge clock) begin
    #4;
    if (reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("tx_pop_unexpected", 32'(tx_data), 32'h100);
      else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // one bus cycle: drive after the rising edge, sample after the falling edge
  task automatic bus_cycle(input logic [11:0] addr, input logic [31:0] wdata, input logic we);
    @(posedge clock);
    #1;
    address_dmem = addr;
    data         = wdata;
    wren         = we;
    #1;
    r_wren_seen  = mem_wren;
    @(negedge clock);
    #1;
    r_q       = q_dmem;
    r_q_small = q_small;
    wren      = 1'b0;
  endtask

  task automatic bus_write(input logic [11:0] addr, input logic [31:0] wdata);
    bus_cycle(addr, wdata, 1'b1);
  endtask

  task automatic bus_read(input logic [11:0] addr);
    bus_cycle(addr, 32'h0, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic expect_accept);
    if (expect_accept) exp_q.push_back(b);
    bus_write(A_TXDATA, {24'h0, b});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; address_dmem = '0; data = '0; wren = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_probe", probe, 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    reset = 1'b1;

    bus_read(A_STATUS);
    check("status_after_reset", r_q, 32'h1);
    bus_read(A_CYCLE);
    v0 = r_q;
    bus_read(A_CYCLE);
    bus_read(A_CYCLE);
    check("cycle_delta2", r_q, v0 + 32'd2);

    // dmem pass-through and probe
    bus_write(12'h010, 32'hDEADBEEF);
    check("dmem_wren", 32'(r_wren_seen), 32'h1);
    bus_read(12'h010);
    check("dmem_read", r_q, 32'hDEADBEEF);
    bus_write(A_PROBE, 32'h1234);
    check("probe_wren", 32'(r_wren_seen), 32'h0);
    check("probe_out", probe, 32'h1234);
    bus_read(A_PROBE);
    check("probe_read", r_q, 32'h1234);
    bus_read(A_TXDATA);
    check("txdata_read", r_q, 32'h0);
    bus_read(12'hF04);
    check("off4_read", r_q, 32'h0);
    bus_write(12'hF06, 32'hFFFF_FFFF);
    check("off6_wren", 32'(r_wren_seen), 32'h0);

    // fill, overflow, drain
    for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i), 1'b1);
    bus_read(A_STATUS);
    check("status_full", r_q, 32'h28);
    push_byte(8'h45, 1'b0);
    bus_read(A_STATUS);
    check("status_ovf", r_q, 32'h128);
    tx_ready = 1'b1;
    repeat (6) bus_read(12'h000);
    check("drain_tx_valid", 32'(tx_valid), 32'h0);
    check("drain_exp_empty", 32'(exp_q.size()), 32'h0);
    tx_ready = 1'b0;
    bus_write(A_STATUS, 32'h100);
    bus_read(A_STATUS);
    check("ovf_cleared", r_q, 32'h1);

    // push into a full FIFO while the sink pops on the same edge
    for (int i = 0; i < 4; i++) push_byte(8'h61 + 8'(i), 1'b1);
    bus_read(A_STATUS);
    check("status_full2", r_q, 32'h28);
    tx_ready = 1'b1;
    push_byte(8'h55, 1'b1);
    bus_read(A_STATUS);
    check("status_full_no_ovf", r_q, 32'h28);
    repeat (5) bus_read(12'h000);
    check("drain2_tx_valid", 32'(tx_valid), 32'h0);
    check("drain2_exp_empty", 32'(exp_q.size()), 32'h0);
    tx_ready = 1'b0;
    bus_read(A_STATUS);
    check("status_empty2", r_q, 32'h1);

    // CYCLE clear and wrap (second instance has a 4-bit counter)
    bus_write(A_CYCLE, 32'hABCD);
    bus_read(12'h000);
    bus_read(A_CYCLE);
    check("cycle_after_clear", r_q, 32'h1);
    check("small_after_clear", r_q_small, 32'h1);
    for (int k = 3; k <= 17; k++) begin
      bus_read(A_CYCLE);
      if (k == 16) check("small_max", r_q_small, 32'hF);
      if (k == 17) check("small_wrap", r_q_small, 32'h0);
      if (k == 17) check("cycle_no_wrap", r_q, 32'd16);
    end

    // asynchronous reset while bytes are queued
    for (int i = 0; i < 3; i++) push_byte(8'h71 + 8'(i), 1'b1);
    check("pre_reset_valid", 32'(tx_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(tx_valid), 32'h0);
    check("async_rst_data", 32'(tx_data), 32'h0);
    exp_q.delete();
    @(posedge clock);
    #2;
    reset = 1'b1;
    bus_read(A_STATUS);
    check("status_after_rst2", r_q, 32'h1);
    check("probe_after_rst2", probe, 32'h0);
    check("final_exp_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
